// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the instruction encoder/loader: formats, field
// positions, halt opcode, error codes and immediate range helper.
package cpu_isa_pkg;

  typedef enum logic [1:0] {
    FMT_R    = 2'd0,
    FMT_I16  = 2'd1,
    FMT_I11  = 2'd2,
    FMT_I11S = 2'd3
  } fmt_e;

  localparam logic [10:0] OPC_HALT = 11'h7FF;

  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 21;
  localparam int REGIN_MSB   = 20;
  localparam int REGIN_LSB   = 16;
  localparam int REGA_MSB    = 15;
  localparam int REGA_LSB    = 11;
  localparam int REGB_MSB    = 10;
  localparam int REGB_LSB    = 6;
  localparam int IMM16_MSB   = 15;
  localparam int IMM16_LSB   = 0;
  localparam int IMM11_MSB   = 10;
  localparam int IMM11_LSB   = 0;
  localparam int IMM3_HI_MSB = 20;
  localparam int IMM3_HI_LSB = 16;
  localparam int IMM3_LO_MSB = 5;
  localparam int IMM3_LO_LSB = 0;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RANGE    = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;

  // Signed fits when every bit above the field's sign bit copies it;
  // unsigned fits when every bit above the field is zero.
  function automatic logic imm_fits(input logic [31:0] imm,
                                    input logic        is_signed,
                                    input logic        narrow);
    logic fits;
    if (narrow) begin
      if (is_signed) begin
        fits = (imm[31:10] == 22'h000000) || (imm[31:10] == 22'h3FFFFF);
      end else begin
        fits = (imm[31:11] == 21'h000000);
      end
    end else begin
      if (is_signed) begin
        fits = (imm[31:15] == 17'h00000) || (imm[31:15] == 17'h1FFFF);
      end else begin
        fits = (imm[31:16] == 16'h0000);
      end
    end
    return fits;
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: places instruction fields into the 32-bit layout
// and reports whether the immediate fits the selected format.
module instr_field_packer
  import cpu_isa_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [10:0] opcode,
  input  logic [4:0]  reg_in,
  input  logic [4:0]  reg_a,
  input  logic [4:0]  reg_b,
  input  logic [31:0] imm,
  input  logic        imm_signed,
  output logic [31:0] word,
  output logic        range_ok
);

  // Field placement and range check per format
  always_comb begin
    word = 32'd0;
    range_ok = 1'b1;
    word[OPC_MSB:OPC_LSB] = opcode;
    case (fmt)
      FMT_R: begin
        word[REGIN_MSB:REGIN_LSB] = reg_in;
        word[REGA_MSB:REGA_LSB]   = reg_a;
        word[REGB_MSB:REGB_LSB]   = reg_b;
        range_ok = 1'b1;
      end
      FMT_I16: begin
        word[REGIN_MSB:REGIN_LSB] = reg_in;
        word[IMM16_MSB:IMM16_LSB] = imm[15:0];
        range_ok = imm_fits(imm, imm_signed, 1'b0);
      end
      FMT_I11: begin
        word[REGIN_MSB:REGIN_LSB] = reg_in;
        word[REGA_MSB:REGA_LSB]   = reg_a;
        word[IMM11_MSB:IMM11_LSB] = imm[10:0];
        range_ok = imm_fits(imm, imm_signed, 1'b1);
      end
      FMT_I11S: begin
        // Upper immediate bits borrow the reg_in slot
        word[IMM3_HI_MSB:IMM3_HI_LSB] = imm[10:6];
        word[REGA_MSB:REGA_LSB]       = reg_a;
        word[REGB_MSB:REGB_LSB]       = reg_b;
        word[IMM3_LO_MSB:IMM3_LO_LSB] = imm[5:0];
        range_ok = imm_fits(imm, imm_signed, 1'b1);
      end
      default: begin
        word = 32'd0;
        range_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Instruction encoder/loader: accepts field bundles, encodes them and writes
// them to instruction RAM at an auto-incrementing address.
module instr_encode_loader
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [10:0]       opcode,
  input  logic [4:0]        reg_in,
  input  logic [4:0]        reg_a,
  input  logic [4:0]        reg_b,
  input  logic [31:0]       imm,
  input  logic              imm_signed,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  state_e            state_r;
  state_e            state_next_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic [1:0]        err_code_r;

  logic [31:0] word_s;
  logic        range_ok_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        overflow_s;
  logic        write_s;

  instr_field_packer u_packer (
    .fmt        (fmt_e'(fmt)),
    .opcode     (opcode),
    .reg_in     (reg_in),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .imm        (imm),
    .imm_signed (imm_signed),
    .word       (word_s),
    .range_ok   (range_ok_s)
  );

  // Handshake qualifiers; start always beats a bundle in the same cycle
  always_comb begin
    in_ready_s = (state_r == ST_LOAD) && !start;
    accept_s   = in_valid && in_ready_s;
    overflow_s = (count_r == DEPTH_C);
    write_s    = accept_s && !overflow_s && range_ok_s;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_LOAD;
        else       state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (start)                    state_next_s = ST_LOAD;
        else if (!accept_s)           state_next_s = ST_LOAD;
        else if (!write_s)            state_next_s = ST_ERROR;
        else if (opcode == OPC_HALT)  state_next_s = ST_DONE;
        else                          state_next_s = ST_LOAD;
      end
      ST_DONE, ST_ERROR: begin
        if (start) state_next_s = ST_LOAD;
        else       state_next_s = state_r;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Write port, pointer, word count and error code registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 32'd0;
      ptr_r       <= {ADDR_W{1'b0}};
      count_r     <= {(ADDR_W+1){1'b0}};
      err_code_r  <= ERR_NONE;
    end else begin
      mem_we_r <= write_s;
      if (write_s) begin
        mem_addr_r  <= ptr_r;
        mem_wdata_r <= word_s;
      end
      if (start) begin
        ptr_r      <= {ADDR_W{1'b0}};
        count_r    <= {(ADDR_W+1){1'b0}};
        err_code_r <= ERR_NONE;
      end else if (write_s) begin
        ptr_r   <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
      end else if (accept_s && overflow_s) begin
        err_code_r <= ERR_OVERFLOW;
      end else if (accept_s) begin
        err_code_r <= ERR_RANGE;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign word_count = count_r;
  assign err_code   = err_code_r;
  assign busy       = (state_r == ST_LOAD);
  assign done       = (state_r == ST_DONE);
  assign error      = (state_r == ST_ERROR);

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: a default-depth and a 4-word instance share
// stimulus and are checked every cycle against a behavioural model.
module tb_instr_encode_loader;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  typedef struct {
    int          mode;
    int          ptr;
    int          cnt;
    int          errc;
    bit          we;
    int          addr;
    logic [31:0] wdata;
  } model_t;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] v;
    logic        sgn;
    logic        ok;
  } rng_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  fmt = 2'd0;
  logic [10:0] opcode = 11'd0;
  logic [4:0]  reg_in = 5'd0;
  logic [4:0]  reg_a = 5'd0;
  logic [4:0]  reg_b = 5'd0;
  logic [31:0] imm = 32'd0;
  logic        imm_signed = 1'b0;

  logic        rdy_b, we_b, busy_b, done_b, err_b;
  logic [7:0]  addr_b;
  logic [31:0] wd_b;
  logic [8:0]  cnt_b;
  logic [1:0]  ec_b;
  logic        rdy_s, we_s, busy_s, done_s, err_s;
  logic [1:0]  addr_s;
  logic [31:0] wd_s;
  logic [2:0]  cnt_s;
  logic [1:0]  ec_s;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  model_t mb = '{M_IDLE, 0, 0, 0, 1'b0, 0, 32'd0};
  model_t ms = '{M_IDLE, 0, 0, 0, 1'b0, 0, 32'd0};

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
    .fmt(fmt), .opcode(opcode), .reg_in(reg_in), .reg_a(reg_a), .reg_b(reg_b),
    .imm(imm), .imm_signed(imm_signed), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wd_b), .word_count(cnt_b), .busy(busy_b), .done(done_b),
    .error(err_b), .err_code(ec_b)
  );

  instr_encode_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(rdy_s),
    .fmt(fmt), .opcode(opcode), .reg_in(reg_in), .reg_a(reg_a), .reg_b(reg_b),
    .imm(imm), .imm_signed(imm_signed), .mem_we(we_s), .mem_addr(addr_s),
    .mem_wdata(wd_s), .word_count(cnt_s), .busy(busy_s), .done(done_s),
    .error(err_s), .err_code(ec_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding by field weights: opcode * 2^21, reg_in * 2^16, reg_a * 2^11, reg_b * 2^6
  function automatic logic [31:0] model_word();
    longint unsigned w;
    longint unsigned u = imm;
    w = longint'(opcode) * 2097152;
    case (fmt)
      2'd0: w += longint'(reg_in) * 65536 + longint'(reg_a) * 2048 + longint'(reg_b) * 64;
      2'd1: w += longint'(reg_in) * 65536 + (u % 65536);
      2'd2: w += longint'(reg_in) * 65536 + longint'(reg_a) * 2048 + (u % 2048);
      default: w += ((u / 64) % 32) * 65536 + longint'(reg_a) * 2048 +
                    longint'(reg_b) * 64 + (u % 64);
    endcase
    return w[31:0];
  endfunction

  function automatic bit model_fits();
    int  sv  = $signed(imm);
    longint unsigned u = imm;
    bit  wide = (fmt == 2'd1);
    if (fmt == 2'd0) return 1'b1;
    if (imm_signed) return wide ? (sv >= -32768 && sv <= 32767) : (sv >= -1024 && sv <= 1023);
    return wide ? (u < 65536) : (u < 2048);
  endfunction

  function automatic model_t step(input model_t m, input int depth);
    model_t n = m;
    n.we = 1'b0;
    if (start) begin
      n.mode = M_LOAD; n.ptr = 0; n.cnt = 0; n.errc = 0;
    end else if (m.mode == M_LOAD && in_valid) begin
      if (m.cnt == depth) begin
        n.mode = M_ERR; n.errc = 2;
      end else if (!model_fits()) begin
        n.mode = M_ERR; n.errc = 1;
      end else begin
        n.we = 1'b1; n.addr = m.ptr; n.wdata = model_word();
        n.ptr = m.ptr + 1; n.cnt = m.cnt + 1;
        if (opcode == 11'h7FF) n.mode = M_DONE;
      end
    end
    return n;
  endfunction

  // Model advances on the same edges as the DUT
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mb <= '{M_IDLE, 0, 0, 0, 1'b0, 0, 32'd0};
      ms <= '{M_IDLE, 0, 0, 0, 1'b0, 0, 32'd0};
    end else begin
      mb <= step(mb, 256);
      ms <= step(ms, 4);
    end
  end

  // Every-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("big.mem_we", {31'd0, we_b}, {31'd0, mb.we});
      if (mb.we) begin
        chk("big.mem_addr", {24'd0, addr_b}, mb.addr);
        chk("big.mem_wdata", wd_b, mb.wdata);
      end
      chk("big.word_count", {23'd0, cnt_b}, mb.cnt);
      chk("big.err_code", {30'd0, ec_b}, mb.errc);
      chk("big.busy", {31'd0, busy_b}, {31'd0, mb.mode == M_LOAD});
      chk("big.done", {31'd0, done_b}, {31'd0, mb.mode == M_DONE});
      chk("big.error", {31'd0, err_b}, {31'd0, mb.mode == M_ERR});
      chk("big.in_ready", {31'd0, rdy_b}, {31'd0, mb.mode == M_LOAD && !start});
      chk("small.mem_we", {31'd0, we_s}, {31'd0, ms.we});
      if (ms.we) begin
        chk("small.mem_addr", {30'd0, addr_s}, ms.addr);
        chk("small.mem_wdata", wd_s, ms.wdata);
      end
      chk("small.word_count", {29'd0, cnt_s}, ms.cnt);
      chk("small.err_code", {30'd0, ec_s}, ms.errc);
      chk("small.busy", {31'd0, busy_s}, {31'd0, ms.mode == M_LOAD});
      chk("small.done", {31'd0, done_s}, {31'd0, ms.mode == M_DONE});
      chk("small.error", {31'd0, err_s}, {31'd0, ms.mode == M_ERR});
      chk("small.in_ready", {31'd0, rdy_s}, {31'd0, ms.mode == M_LOAD && !start});
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] f, input logic [10:0] op, input logic [4:0] ri,
                      input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] iv,
                      input logic sg);
    fmt = f; opcode = op; reg_in = ri; reg_a = ra; reg_b = rb; imm = iv; imm_signed = sg;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  rng_t rng [12];

  initial begin
    rng[0]  = '{2'd1, 32'h0000FFFF, 1'b0, 1'b1};
    rng[1]  = '{2'd1, 32'h00010000, 1'b0, 1'b0};
    rng[2]  = '{2'd1, 32'hFFFF8000, 1'b1, 1'b1};
    rng[3]  = '{2'd1, 32'h00007FFF, 1'b1, 1'b1};
    rng[4]  = '{2'd1, 32'hFFFF7FFF, 1'b1, 1'b0};
    rng[5]  = '{2'd2, 32'h000007FF, 1'b0, 1'b1};
    rng[6]  = '{2'd2, 32'h00000800, 1'b0, 1'b0};
    rng[7]  = '{2'd2, 32'hFFFFFC00, 1'b1, 1'b1};
    rng[8]  = '{2'd2, 32'hFFFFFBFF, 1'b1, 1'b0};
    rng[9]  = '{2'd3, 32'h000003FF, 1'b1, 1'b1};
    rng[10] = '{2'd3, 32'h00000400, 1'b1, 1'b0};
    rng[11] = '{2'd0, 32'hDEADBEEF, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("rst.mem_we", {31'd0, we_b}, 32'd0);
    chk("rst.mem_addr", {24'd0, addr_b}, 32'd0);
    chk("rst.mem_wdata", wd_b, 32'd0);
    chk("rst.word_count", {23'd0, cnt_b}, 32'd0);
    chk("rst.err_code", {30'd0, ec_b}, 32'd0);
    chk("rst.busy", {31'd0, busy_b}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    pulse_start();
    send(2'd0, 11'h005, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("r.we", {31'd0, we_b}, 32'd1);
    chk("r.addr", {24'd0, addr_b}, 32'd0);
    chk("r.wdata", wd_b, 32'h00A30880);
    chk("r.count", {23'd0, cnt_b}, 32'd1);

    pulse_start();
    send(2'd1, 11'h040, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
    chk("i16.we", {31'd0, we_b}, 32'd1);
    chk("i16.wdata", wd_b, 32'h0805FFFF);
    send(2'd3, 11'h400, 5'd0, 5'd4, 5'd6, 32'hFFFFFFFE, 1'b1);
    chk("i11s.we", {31'd0, we_b}, 32'd1);
    chk("i11s.addr", {24'd0, addr_b}, 32'd1);
    chk("i11s.wdata", wd_b, 32'h801F21BE);

    pulse_start();
    send(2'd1, 11'h040, 5'd5, 5'd0, 5'd0, 32'd32768, 1'b1);
    chk("rng.we", {31'd0, we_b}, 32'd0);
    chk("rng.error", {31'd0, err_b}, 32'd1);
    chk("rng.err_code", {30'd0, ec_b}, 32'd1);
    chk("rng.in_ready", {31'd0, rdy_b}, 32'd0);
    pulse_start();
    chk("restart.busy", {31'd0, busy_b}, 32'd1);
    chk("restart.err_code", {30'd0, ec_b}, 32'd0);
    chk("restart.count", {23'd0, cnt_b}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      pulse_start();
      send(rng[i].f, 11'h123, 5'd7, 5'd9, 5'd11, rng[i].v, rng[i].sgn);
      chk("bound.we", {31'd0, we_b}, {31'd0, rng[i].ok});
      chk("bound.error", {31'd0, err_b}, {31'd0, !rng[i].ok});
    end

    pulse_start();
    send(2'd0, 11'h7FF, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    chk("halt.wdata", wd_b, 32'hFFE00000);
    chk("halt.done", {31'd0, done_b}, 32'd1);
    chk("halt.in_ready", {31'd0, rdy_b}, 32'd0);
    send(2'd0, 11'h001, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    chk("halt.nowrite", {31'd0, we_b}, 32'd0);

    pulse_start();
    for (int i = 0; i < 5; i++) begin
      send(2'd0, 11'h010 + 11'(i), 5'(i), 5'd2, 5'd3, 32'd0, 1'b0);
      if (i == 3) chk("ovf.addr3", {30'd0, addr_s}, 32'd3);
    end
    chk("ovf.we", {31'd0, we_s}, 32'd0);
    chk("ovf.error", {31'd0, err_s}, 32'd1);
    chk("ovf.err_code", {30'd0, ec_s}, 32'd2);
    chk("ovf.count", {29'd0, cnt_s}, 32'd4);
    chk("ovf.big_addr4", {24'd0, addr_b}, 32'd4);

    pulse_start();
    send(2'd0, 11'h020, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    start = 1'b1;
    send(2'd0, 11'h021, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0);
    start = 1'b0;
    chk("startwin.we", {31'd0, we_b}, 32'd0);
    send(2'd0, 11'h022, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0);
    chk("startwin.addr", {24'd0, addr_b}, 32'd0);
    chk("startwin.we2", {31'd0, we_b}, 32'd1);

    pulse_start();
    fmt = 2'd0; opcode = 11'h033; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.mem_we", {31'd0, we_b}, 32'd0);
    chk("arst.mem_addr", {24'd0, addr_b}, 32'd0);
    chk("arst.mem_wdata", wd_b, 32'd0);
    chk("arst.count", {23'd0, cnt_b}, 32'd0);
    chk("arst.busy", {31'd0, busy_b}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("arst.stay_idle", {31'd0, we_b}, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
